// File: rtl/uart_tx_fifo.sv
// UART transmitter with a small input FIFO. Data width, parity and stop bits are configurable.
// Frames are sent back-to-back whenever the FIFO holds another word at the end of a stop period.
module uart_tx_fifo #(
  parameter int CLK_FREQ   = 5_000_000,
  parameter int BAUD_RATE  = 9600,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [DATA_BITS-1:0]        s_data,
  input  logic                        s_valid,
  output logic                        s_ready,
  output logic                        tx,
  output logic                        busy,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count
);

  localparam int BAUD_DIV = (BAUD_RATE > 0) ? CLK_FREQ / BAUD_RATE : 0;
  localparam int CW       = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
  localparam int AW       = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

  localparam logic [CW-1:0] BAUD_LAST = CW'(BAUD_DIV - 1);
  localparam logic [AW:0]   FULL_CNT  = (AW+1)'(FIFO_DEPTH);
  localparam logic [3:0]    LAST_DATA = 4'(DATA_BITS - 1);
  localparam logic [3:0]    LAST_STOP = 4'(STOP_BITS - 1);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
  localparam logic [2:0] S_PARITY = 3'd3;
  localparam logic [2:0] S_STOP   = 3'd4;

  if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
    $error("uart_tx_fifo: DATA_BITS must be 5..9");
  end
  if (PARITY < 0 || PARITY > 2) begin : g_bad_parity
    $error("uart_tx_fifo: PARITY must be 0, 1 or 2");
  end
  if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop_bits
    $error("uart_tx_fifo: STOP_BITS must be 1 or 2");
  end
  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_fifo_depth
    $error("uart_tx_fifo: FIFO_DEPTH must be a power of two >= 2");
  end
  if (BAUD_DIV < 2) begin : g_bad_baud_div
    $error("uart_tx_fifo: CLK_FREQ/BAUD_RATE must be at least 2");
  end

  logic [DATA_BITS-1:0] mem_q [FIFO_DEPTH];
  logic [AW-1:0]        wr_ptr_q, rd_ptr_q;
  logic [AW:0]          count_q, count_d;
  logic                 push, pop, load, nonempty;
  logic [DATA_BITS-1:0] head;

  logic [2:0]           state_q, state_d;
  logic [CW-1:0]        baud_q, baud_d;
  logic [3:0]           bit_q, bit_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 par_q, par_d;
  logic                 tx_q, tx_d;
  logic                 busy_q, busy_d;
  logic                 tick;

  assign s_ready    = (count_q != FULL_CNT);
  assign push       = s_valid && s_ready;
  assign nonempty   = (count_q != '0);
  assign head       = mem_q[rd_ptr_q];
  assign tick       = (baud_q == BAUD_LAST);
  assign tx         = tx_q;
  assign busy       = busy_q;
  assign fifo_count = count_q;

  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= s_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_d;
    end
  end

  always_comb begin
    state_d = state_q;
    baud_d  = tick ? '0 : baud_q + CW'(1);
    bit_d   = bit_q;
    shift_d = shift_q;
    par_d   = par_q;
    tx_d    = tx_q;
    busy_d  = busy_q;
    load    = 1'b0;
    case (state_q)
      S_IDLE: begin
        baud_d = '0;
        tx_d   = 1'b1;
        busy_d = 1'b0;
        if (nonempty) load = 1'b1;
      end
      S_START: begin
        if (tick) begin
          state_d = S_DATA;
          tx_d    = shift_q[0];
          bit_d   = '0;
        end
      end
      S_DATA: begin
        if (tick) begin
          if (bit_q == LAST_DATA) begin
            if (PARITY != 0) begin
              state_d = S_PARITY;
              tx_d    = par_q;
            end else begin
              state_d = S_STOP;
              tx_d    = 1'b1;
              bit_d   = '0;
            end
          end else begin
            shift_d = shift_q >> 1;
            tx_d    = shift_q[1];
            bit_d   = bit_q + 4'd1;
          end
        end
      end
      S_PARITY: begin
        if (tick) begin
          state_d = S_STOP;
          tx_d    = 1'b1;
          bit_d   = '0;
        end
      end
      S_STOP: begin
        if (tick) begin
          if (bit_q == LAST_STOP) begin
            // Another word waiting: skip IDLE so the next start bit follows with no gap.
            if (nonempty) begin
              load = 1'b1;
            end else begin
              state_d = S_IDLE;
              busy_d  = 1'b0;
              tx_d    = 1'b1;
            end
          end else begin
            bit_d = bit_q + 4'd1;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
        tx_d    = 1'b1;
        busy_d  = 1'b0;
      end
    endcase
    if (load) begin
      state_d = S_START;
      shift_d = head;
      par_d   = (PARITY == 1) ? ~(^head) : ^head;
      baud_d  = '0;
      bit_d   = '0;
      tx_d    = 1'b0;
      busy_d  = 1'b1;
    end
  end

  assign pop = load;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      par_q   <= 1'b0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      par_q   <= par_d;
      tx_q    <= tx_d;
      busy_q  <= busy_d;
    end
  end

endmodule

// File: doc/uart_tx_fifo.md
# uart_tx_fifo

Parametrised UART transmitter, successor to the fixed 8N1 transmitter. It adds configurable data width, optional odd/even parity, one or two stop bits, and a ready/valid input buffered by a small FIFO. Frames leave back-to-back with no idle gap. It sits between a byte-stream producer and the serial `tx` pin, in the same clock domain as the producer.

## Interface
- `CLK_FREQ`, 5_000_000: clock frequency in Hz.
- `BAUD_RATE`, 9600: line rate in bit/s.
- `DATA_BITS`, 8: data bits per frame, legal range 5..9.
- `PARITY`, 0: parity mode; 0 = none, 1 = odd, 2 = even.
- `STOP_BITS`, 1: stop bits per frame, 1 or 2.
- `FIFO_DEPTH`, 4: input FIFO entries; power of two, ≥2.
- `clk`  in  1  system clock; all logic is clocked on the rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `s_data`  in  DATA_BITS  word to transmit.
- `s_valid`  in  1  `s_data` is valid.
- `s_ready`  out  1  FIFO not full. Combinational from the registered FIFO count.
- `tx`  out  1  serial line, registered, idles high.
- `busy`  out  1  a frame is in progress (FSM not IDLE), registered.
- `fifo_count`  out  $clog2(FIFO_DEPTH)+1  occupied FIFO entries, registered.

## Operation
- Out-of-range parameters must fail elaboration.
- `BAUD_DIV = CLK_FREQ/BAUD_RATE`, using integer truncation.
  - Every line bit lasts exactly `BAUD_DIV` clocks.
  - The baud counter is `$clog2(BAUD_DIV)` bits wide, counts 0..BAUD_DIV-1, and wraps.
- Push: a word is accepted on any edge where `s_valid && s_ready`. `s_data` is then written at the tail.
- Pop: the FSM pops the head on an edge where it leaves IDLE or STOP for START with the FIFO non-empty.
  - Push and pop on the same edge leave `fifo_count` unchanged.
- FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE: `tx`=1. If the FIFO is non-empty, pop into the shift register, compute parity, clear the baud counter, and go to START.
  - START: `tx`=0 for one bit time, then go to DATA.
  - DATA: shift out `DATA_BITS` bits, LSB first, one per bit time. Then go to PARITY if `PARITY`≠0, else STOP.
  - PARITY: one bit time.
    - Even parity sends the XOR of the data bits.
    - Odd parity sends its inverse.
  - STOP: `tx`=1 for `STOP_BITS` bit times. At the end:
    - FIFO non-empty: pop and go directly to START. `tx` falls on the same edge that ends the stop period.
    - FIFO empty: go to IDLE.
- Frame length is `(1+DATA_BITS+(PARITY!=0)+STOP_BITS)*BAUD_DIV` clocks.
- `s_data` changes after acceptance do not affect a queued or active frame.
- Reset mid-frame aborts the frame and empties the FIFO. The partial frame is never resumed.

## Timing
- Reset values:
  - `tx`=1, `busy`=0, `fifo_count`=0, FSM in IDLE.
  - `s_ready`=1 (count is 0); pushes are impossible while `rst_n` is low.
- Latency when idle: word accepted on edge N → popped on edge N+1 → `tx`=0 and `busy`=1 from edge N+1.
- Each bit transition on `tx` occurs exactly `BAUD_DIV` edges after the previous one.
- `busy` falls on the edge `tx` would begin a next START, if the FIFO is empty at that point.
- Full FIFO: `s_ready`=0 while `fifo_count`==FIFO_DEPTH. It rises the cycle after the pop edge.
- A push is never accepted when full, so there is no overflow. Pops never occur when empty, so there is no underflow.
- After `rst_n` deasserts, the first push is accepted on the first rising edge with `s_valid`=1.

## Test plan
- 8N1 timing (defaults, BAUD_DIV=520):
  - Stimulus: push 0xA5 while idle.
  - Required response: `tx` = 0,1,0,1,0,0,1,0,1,1, each level held exactly 520 clocks; `tx` falls one edge after acceptance.
  - Then `busy`=0 and `tx`=1 at 5200 clocks.
- Even parity: `DATA_BITS`=7, `PARITY`=2.
  - Stimulus: push 0x41.
  - Required response: data bits 1,0,0,0,0,0,1, then parity 0, then stop 1.
- Odd parity and two stop bits: `PARITY`=1, `STOP_BITS`=2.
  - Stimulus: push 0x00.
  - Required response: parity bit 1, then `tx` high for 1040 clocks; total frame 6240 clocks.
- FIFO full: hold `s_valid`=1 for 6 consecutive cycles from idle (depth 4).
  - Required response: exactly 5 words accepted; `fifo_count` reaches 4 and `s_ready`=0 on the sixth cycle.
  - The 5 frames go out back-to-back with zero idle clocks between the stop bit and the next start bit.
  - `s_ready` returns to 1 one cycle after the second pop.
- Reset mid-frame:
  - Stimulus: assert `rst_n`=0 for 3 clocks during DATA of the first of 3 queued frames.
  - Required response: `tx`=1 immediately (asynchronous), `fifo_count`=0, `busy`=0; no further frames are transmitted.
- Truncated divisor: `CLK_FREQ`=1_000_000, `BAUD_RATE`=115200.
  - Required response: every bit lasts exactly 8 clocks.
